// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state type and helpers for the difference unit.
// Contents: DW_DEFAULT (default sample width), diff_state_e (FILL/RUN),
// ptr_width() (ring-pointer width that stays at least one bit wide).
package fft_pkg;
   localparam int DW_DEFAULT = 16;
   typedef enum logic {FILL = 1'b0, RUN = 1'b1} diff_state_e;
   function automatic int ptr_width(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/difference_unit_if.sv
// difference_unit_if: valid/ready sample stream into and result stream out of the difference unit.
// Signals: in_valid/in_ready/val_a (input stream), out_valid/out_ready/val_out (result stream).
// Modports: master = surrounding logic driving samples and taking results, slave = the unit.
interface difference_unit_if import fft_pkg::*; #(
   parameter int DW = DW_DEFAULT
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] val_a;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW:0]   val_out;
   modport master (output in_valid, val_a, out_ready, input in_ready, out_valid, val_out);
   modport slave  (input in_valid, val_a, out_ready, output in_ready, out_valid, val_out);
endinterface

// File: rtl/diff_delay_line.sv
// diff_delay_line: DELAY-entry ring buffer returning the sample written DELAY writes ago.
// Ports: clk, rst_n (async, active-low), flush (sync clear of entries and pointer),
//        wr_en (overwrite the oldest entry with din), din (sample in), oldest (entry at pointer).
module diff_delay_line import fft_pkg::*; #(
   parameter int DW    = DW_DEFAULT,
   parameter int DELAY = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic signed [DW-1:0] din,
   output logic signed [DW-1:0] oldest
);
   localparam int PW = ptr_width(DELAY);
   logic signed [DW-1:0] buf_q [DELAY];
   logic [PW-1:0]        ptr_q;
   // Read and overwrite share one slot: the pointer always addresses the oldest entry.
   assign oldest = buf_q[ptr_q];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         for (int i = 0; i < DELAY; i++) buf_q[i] <= '0;
      end else if (flush) begin
         ptr_q <= '0;
         for (int i = 0; i < DELAY; i++) buf_q[i] <= '0;
      end else if (wr_en) begin
         buf_q[ptr_q] <= din;
         ptr_q        <= (ptr_q == PW'(DELAY - 1)) ? '0 : ptr_q + 1'b1;
      end
   end
endmodule

// File: rtl/difference_unit.sv
// difference_unit: registered comb difference val_out = x[n] - x[n-DELAY] on a valid/ready stream.
// Ports: clk, rst_n (async, active-low), flush (sync clear of delay line and fill state),
//        primed (DELAY samples accepted since reset/flush), bus (difference_unit_if.slave).
// Option: define DIFF_SAT_EN to clamp the result to the DW-bit signed range (sign-extended).
module difference_unit import fft_pkg::*; #(
   parameter int DW    = DW_DEFAULT,
   parameter int DELAY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   output logic              primed,
   difference_unit_if.slave  bus
);
   localparam int CW = $clog2(DELAY + 1);
   diff_state_e          state_q, state_d;
   logic [CW-1:0]        count_q;
   logic                 accept;
   logic                 out_valid_q;
   logic signed [DW:0]   val_out_q;
   logic signed [DW-1:0] oldest, past;
   logic signed [DW:0]   diff, result;
   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.val_out   = val_out_q;
   assign accept        = bus.in_valid && bus.in_ready;
   diff_delay_line #(.DW(DW), .DELAY(DELAY)) u_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .wr_en  (accept),
      .din    (bus.val_a),
      .oldest (oldest)
   );
   // Until the line has been filled, the delayed sample is defined as zero.
   assign past = (state_q == RUN) ? oldest : '0;
   assign diff = {bus.val_a[DW-1], bus.val_a} - {past[DW-1], past};
`ifdef DIFF_SAT_EN
   // Overflow out of DW bits shows as the top two bits disagreeing; clamp toward the sign.
   assign result = (diff[DW] == diff[DW-1]) ? diff : {diff[DW], diff[DW], {(DW-1){~diff[DW]}}};
`else
   assign result = diff;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = flush ? FILL :
                (state_q == FILL && accept && count_q == CW'(DELAY - 1)) ? RUN : state_q;
   end
   always_comb begin
      primed = (state_q == RUN);
   end
   // Counts only while filling, so it rests at DELAY once running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            count_q <= '0;
      else if (flush)                        count_q <= '0;
      else if (accept && state_q == FILL)    count_q <= count_q + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         val_out_q   <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         val_out_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         val_out_q   <= result;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_difference_unit.sv
// tb_difference_unit: three difference units (DELAY 4, 1, 3) checked against a queue-based model.
module tb_difference_unit;
   import fft_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic              rst_n     [3];
   logic              flush     [3];
   logic              in_valid  [3];
   logic              out_ready [3];
   logic signed [15:0] val_a    [3];
   int errors = 0;
   int checks = 0;
   int e33 [6] = '{10, 20, 30, 40, 40, 40};
   int e38 [9] = '{1, 2, 3, 3, 3, 3, 3, 3, 3};

   function automatic void chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endfunction

   function automatic longint ref_diff(input longint a, input longint b);
      longint d;
      d = a - b;
`ifdef DIFF_SAT_EN
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
`endif
      return d;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : ch
      localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : 3;
      difference_unit_if #(.DW(16)) bus ();
      logic   primed;
      longint hist [$];
      logic   m_ov = 1'b0;
      longint m_vo = 0;
      longint old;
      assign bus.in_valid  = in_valid[g];
      assign bus.out_ready = out_ready[g];
      assign bus.val_a     = val_a[g];
      difference_unit #(.DW(16), .DELAY(D)) dut (
         .clk    (clk),
         .rst_n  (rst_n[g]),
         .flush  (flush[g]),
         .primed (primed),
         .bus    (bus.slave)
      );
      // Model: hist holds the last (up to D) accepted samples since reset/flush.
      always @(posedge clk or negedge rst_n[g]) begin
         if (!rst_n[g]) begin
            hist.delete();
            m_ov = 1'b0;
            m_vo = 0;
         end else if (flush[g]) begin
            hist.delete();
            m_ov = 1'b0;
         end else if (in_valid[g] && (!m_ov || out_ready[g])) begin
            if (hist.size() == D) old = hist.pop_front();
            else old = 0;
            m_vo = ref_diff(longint'(val_a[g]), old);
            hist.push_back(longint'(val_a[g]));
            m_ov = 1'b1;
         end else if (out_ready[g]) begin
            m_ov = 1'b0;
         end
      end
      always @(negedge clk) begin
         chk($sformatf("ch%0d in_ready", g), longint'(bus.in_ready), longint'(!m_ov || out_ready[g]));
         chk($sformatf("ch%0d out_valid", g), longint'(bus.out_valid), longint'(m_ov));
         chk($sformatf("ch%0d primed", g), longint'(primed), longint'(hist.size() == D));
         if (m_ov) chk($sformatf("ch%0d val_out", g), longint'(bus.val_out), m_vo);
      end
   end

   // Called right after a falling edge: drive just after it, return on the next falling edge.
   task automatic drive(input int c, input logic iv, input logic ordy, input logic fl, input int v);
      #1;
      in_valid[c]  = iv;
      out_ready[c] = ordy;
      flush[c]     = fl;
      val_a[c]     = 16'(v);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1; val_a[i] = '0;
      end
      #1;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
      #20;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      @(negedge clk);
      chk("reset out_valid", longint'(ch[0].bus.out_valid), 0);
      chk("reset val_out", longint'(ch[0].bus.val_out), 0);
      chk("reset primed", longint'(ch[0].primed), 0);
      chk("reset in_ready", longint'(ch[0].bus.in_ready), 1);
      // Basic stream, DELAY=4
      for (int i = 0; i < 6; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 10 * (i + 1));
         chk("stream val_out", longint'(ch[0].bus.val_out), e33[i]);
         chk("stream primed", longint'(ch[0].primed), longint'(i >= 3));
      end
      // Backpressure: 37 - 30 = 7 then hold for three cycles
      drive(0, 1'b1, 1'b1, 1'b0, 37);
      chk("bp first", longint'(ch[0].bus.val_out), 7);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 100);
         chk("bp hold val_out", longint'(ch[0].bus.val_out), 7);
         chk("bp hold in_ready", longint'(ch[0].bus.in_ready), 0);
      end
      drive(0, 1'b1, 1'b1, 1'b0, 100);
      chk("bp resume a", longint'(ch[0].bus.val_out), 60);
      drive(0, 1'b1, 1'b1, 1'b0, 200);
      chk("bp resume b", longint'(ch[0].bus.val_out), 150);
      drive(0, 1'b0, 1'b1, 1'b0, 0);
      chk("bp drain", longint'(ch[0].bus.out_valid), 0);
      // Flush with a simultaneous sample in RUN
      drive(0, 1'b1, 1'b1, 1'b1, 999);
      chk("flush out_valid", longint'(ch[0].bus.out_valid), 0);
      chk("flush primed", longint'(ch[0].primed), 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 5 + i);
         chk("post-flush val_out", longint'(ch[0].bus.val_out), 5 + i);
         chk("post-flush primed", longint'(ch[0].primed), longint'(i == 3));
      end
      drive(0, 1'b1, 1'b1, 1'b0, 9);
      chk("post-flush diff", longint'(ch[0].bus.val_out), 4);
      drive(0, 1'b0, 1'b1, 1'b0, 0);
      // Asynchronous reset with an output pending
      drive(0, 1'b1, 1'b0, 1'b0, 42);
      chk("pending out_valid", longint'(ch[0].bus.out_valid), 1);
      #2 rst_n[0] = 1'b0;
      #1;
      chk("async rst out_valid", longint'(ch[0].bus.out_valid), 0);
      chk("async rst val_out", longint'(ch[0].bus.val_out), 0);
      chk("async rst primed", longint'(ch[0].primed), 0);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      #1 rst_n[0] = 1'b1;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b0, 9);
      chk("after rst val_out", longint'(ch[0].bus.val_out), 9);
      drive(0, 1'b0, 1'b1, 1'b0, 0);
      // DELAY=1 extremes
      drive(1, 1'b1, 1'b1, 1'b0, 32767);
      chk("d1 first", longint'(ch[1].bus.val_out), 32767);
      drive(1, 1'b1, 1'b1, 1'b0, -32768);
`ifdef DIFF_SAT_EN
      chk("d1 second", longint'(ch[1].bus.val_out), -32768);
`else
      chk("d1 second", longint'(ch[1].bus.val_out), -65535);
`endif
      drive(1, 1'b0, 1'b1, 1'b0, 0);
      // Wrap-around, DELAY=3, ramp
      for (int i = 0; i < 9; i++) begin
         drive(2, 1'b1, 1'b1, 1'b0, i + 1);
         chk("wrap val_out", longint'(ch[2].bus.val_out), e38[i]);
      end
      drive(2, 1'b0, 1'b1, 1'b0, 0);
      // Random traffic on all channels
      repeat (400) begin
         #1;
         for (int c = 0; c < 3; c++) begin
            in_valid[c]  = ($urandom_range(0, 9) < 7);
            out_ready[c] = ($urandom_range(0, 9) < 7);
            flush[c]     = ($urandom_range(0, 49) == 0);
            val_a[c]     = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
         end
         @(negedge clk);
      end
      #1;
      for (int c = 0; c < 3; c++) begin
         in_valid[c] = 1'b0; out_ready[c] = 1'b1; flush[c] = 1'b0;
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/difference_unit.md
DIFFERENCE_UNIT -- requirements
Module: difference_unit

Interface
REQ-001 SHALL have parameter DW, default 16, input sample width.
REQ-002 SHALL have parameter DELAY, default 4, legal 1..64, comb delay in accepted samples.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  in  1  synchronous clear of delay line and fill state.
REQ-006 SHALL have port in_valid  in  1  val_a carries a sample.
REQ-007 SHALL have port in_ready  out  1  block can accept a sample this cycle.
REQ-008 SHALL have port val_a  in  DW  signed two's-complement input sample.
REQ-009 SHALL have port out_valid  out  1  val_out holds a result.
REQ-010 SHALL have port out_ready  in  1  downstream takes val_out this cycle.
REQ-011 SHALL have port val_out  out  DW+1  signed difference result.
REQ-012 SHALL have port primed  out  1  DELAY samples accepted since reset/flush.

Function
REQ-013 SHALL accept a sample only when in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL compute val_out = x[n] - x[n-DELAY] at full DW+1 width, sign-extended, with no overflow.
REQ-016 SHALL use zero for x[n-DELAY] while in state FILL.
REQ-017 SHALL register the result: an accepted sample in cycle k gives out_valid high in cycle k+1 (latency 1).
REQ-018 SHALL hold val_out and out_valid stable while out_valid is high and out_ready is low.
REQ-019 SHALL clear out_valid when out_ready is high and no new sample is accepted in the same cycle.
REQ-020 SHALL keep the delay line as a DELAY-entry ring buffer: read the oldest entry and overwrite it with the accepted sample in the same cycle; the pointer wraps DELAY-1 -> 0.
REQ-021 SHALL implement states FILL and RUN:
- FILL -> RUN on the DELAY-th accepted sample.
- RUN stays in RUN until flush or reset.
REQ-022 SHALL count accepted samples 0..DELAY in FILL; the count saturates in RUN.
REQ-023 SHALL drive primed high exactly in state RUN.
REQ-024 SHALL give flush priority over a simultaneous accept: the sample is dropped, out_valid is cleared, and the state returns to FILL with count 0, pointer 0 and all buffer entries zero.
REQ-025 SHALL, when DELAY=1, produce first difference x[n]-x[n-1], with the first output equal to x[0].

Reset
REQ-026 SHALL, on rst_n low and asynchronously, force: state FILL, count 0, pointer 0, buffer zero, out_valid 0, val_out 0, primed 0.
REQ-027 SHALL, after rst_n is released, allow in_ready high from the first rising edge.
REQ-028 SHALL, on reset mid-stream, discard any pending output without emitting it.

Configuration
REQ-029 SHALL, with DIFF_SAT_EN defined, saturate val_out to [-2^(DW-1), 2^(DW-1)-1], sign-extended to DW+1 bits.
REQ-030 SHALL, without DIFF_SAT_EN, output the unsaturated DW+1-bit difference.

Structure
REQ-031 SHALL take the state enum (FILL, RUN) and the DW default constant from a shared package, fft_pkg.
REQ-032 SHALL place the ring buffer with its pointer in sub-module diff_delay_line; the FSM, handshake and arithmetic stay in difference_unit.

Verification
REQ-033 SHALL cover DELAY=4, in_valid held high, out_ready=1, inputs 10,20,30,40,50,60:
- outputs 10,20,30,40,40,40;
- primed rises with the output for 40.
REQ-034 SHALL cover DELAY=1, inputs 32767 then -32768:
- without DIFF_SAT_EN, outputs 32767 then -65535;
- with DIFF_SAT_EN, outputs 32767 then -32768.
REQ-035 SHALL cover backpressure, out_ready=0 for 3 cycles with a valid output of 7:
- val_out holds 7;
- in_ready stays 0;
- no samples are lost after out_ready returns to 1.
REQ-036 SHALL cover flush asserted together with in_valid in RUN (DELAY=4):
- the sample is dropped and out_valid goes to 0;
- the next input 5 outputs 5;
- primed is low until 4 more samples are accepted.
REQ-037 SHALL cover rst_n pulsed low mid-stream with out_valid=1:
- out_valid, val_out and primed go to 0 immediately;
- the next input 9 outputs 9.
REQ-038 SHALL cover wrap-around, DELAY=3, 9 ramp inputs 1..9:
- outputs 1,2,3,3,3,3,3,3,3.
